// File: rtl/dat_rx_deser.sv
// dat_rx_deser -- SD card 4-bit DAT line read-data deserializer.
//
// Waits for a start bit on all four DAT lines, samples 2*block_sz nibbles per
// block, packs them MSB-first into FIFO words and pushes each word with a
// one-cycle strobe. Then it consumes 16 CRC cycles and one end-bit cycle per
// block, and repeats for block_cnt blocks.
//
// Optional feature: define DAT_RX_CRC_EN to check a per-line CRC16
// (x^16+x^12+x^5+1, init 0). Without it, the CRC cycles are skipped and crc_err
// is tied low.
//
// Ports
//   sd_clk          clock, rising edge
//   rst             asynchronous active-high reset
//   DAT_din[3:0]    card DAT lines
//   block_sz        block size in bytes (latched at transfer start)
//   block_cnt       number of blocks (latched at transfer start)
//   read_flag       level request to start a read; sampled only in IDLE
//   rx_buf_full     Rx FIFO full; a push attempted while it is high is dropped
//   rx_buf_wr_enb   one-cycle Rx FIFO push strobe
//   rx_buf_din_out  word pushed to the Rx FIFO
//   rd_busy         high whenever the FSM is not in IDLE
//   rd_finished     one-cycle pulse at the end of a transfer
//   crc_err, end_err, timeout_err, overrun_err
//                   sticky error flags, cleared when the next transfer starts
//
// State table
//   IDLE       | waiting for read_flag
//   WAIT_START | waiting up to NAC_TIMEOUT cycles for DAT == 4'b0000
//   DATA       | sampling one nibble per cycle, packing and pushing words
//   CRC        | 16 cycles of per-line CRC bits
//   END_BIT    | one cycle, expects DAT == 4'b1111
//   DONE       | pulses rd_finished, then returns to IDLE

`ifndef BLOCK_SZ_WIDTH
`define BLOCK_SZ_WIDTH 12
`endif
`ifndef BLOCK_CNT_WIDTH
`define BLOCK_CNT_WIDTH 16
`endif
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 32
`endif

module dat_rx_deser #(
    parameter int NAC_TIMEOUT = 1024
) (
    input  logic                        sd_clk,
    input  logic                        rst,
    input  logic [3:0]                  DAT_din,
    input  logic [`BLOCK_SZ_WIDTH-1:0]  block_sz,
    input  logic [`BLOCK_CNT_WIDTH-1:0] block_cnt,
    input  logic                        read_flag,
    input  logic                        rx_buf_full,
    output logic                        rx_buf_wr_enb,
    output logic [`FIFO_WIDTH-1:0]      rx_buf_din_out,
    output logic                        rd_busy,
    output logic                        rd_finished,
    output logic                        crc_err,
    output logic                        end_err,
    output logic                        timeout_err,
    output logic                        overrun_err
);

    localparam int FW   = `FIFO_WIDTH;
    localparam int SZW  = `BLOCK_SZ_WIDTH;
    localparam int CNTW = `BLOCK_CNT_WIDTH;
    localparam int NRW  = SZW + 1;
    localparam int NPW  = FW / 4;
    localparam int NIW  = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int TMW  = $clog2(NAC_TIMEOUT + 1);

    localparam logic [TMW-1:0] TMO_LOAD = TMW'(NAC_TIMEOUT - 1);
    localparam logic [NIW-1:0] NIB_LAST = NIW'(NPW - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SZW-1:0]    blk_sz_q, blk_sz_d;
    logic [CNTW-1:0]   blk_rem_q, blk_rem_d;
    logic [TMW-1:0]    tmo_q, tmo_d;
    logic [NRW-1:0]    nib_rem_q, nib_rem_d;
    logic [NIW-1:0]    nib_idx_q, nib_idx_d;
    logic [FW-1:0]     word_q, word_d;
    logic [3:0]        crc_cnt_q, crc_cnt_d;
    logic              wr_enb_q, wr_enb_d;
    logic [FW-1:0]     din_out_q, din_out_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic              end_err_q, end_err_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ovr_err_q, ovr_err_d;

    // Word under construction: the sampled nibble is dropped into its final
    // bit position, so a short last word is already zero-filled at the bottom.
    logic [FW-1:0]     word_base;
    logic [FW-1:0]     cur_word;
    int                nib_shift;
    logic              word_end;
    logic              block_end;

    always_comb begin
        word_base = (nib_idx_q == '0) ? '0 : word_q;
        nib_shift = 4 * (NPW - 1 - int'(nib_idx_q));
        cur_word  = word_base | (FW'(DAT_din) << nib_shift);
        block_end = (nib_rem_q == '0);
        word_end  = (nib_idx_q == NIB_LAST) || block_end;
    end

    always_comb begin
        state_d   = state_q;
        blk_sz_d  = blk_sz_q;
        blk_rem_d = blk_rem_q;
        tmo_d     = tmo_q;
        nib_rem_d = nib_rem_q;
        nib_idx_d = nib_idx_q;
        word_d    = word_q;
        crc_cnt_d = crc_cnt_q;
        wr_enb_d  = 1'b0;
        din_out_d = din_out_q;
        fin_d     = 1'b0;
        end_err_d = end_err_q;
        tmo_err_d = tmo_err_q;
        ovr_err_d = ovr_err_q;

        case (state_q)
            IDLE: begin
                if (read_flag) begin
                    blk_sz_d  = block_sz;
                    blk_rem_d = block_cnt;
                    end_err_d = 1'b0;
                    tmo_err_d = 1'b0;
                    ovr_err_d = 1'b0;
                    tmo_d     = TMO_LOAD;
                    if ((block_sz == '0) || (block_cnt == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_START;
                    end
                end
            end
            WAIT_START: begin
                if (DAT_din == 4'b0000) begin
                    state_d   = DATA;
                    nib_rem_d = {blk_sz_q, 1'b0} - NRW'(1);
                    nib_idx_d = '0;
                    word_d    = '0;
                end else if (tmo_q == '0) begin
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_d = tmo_q - TMW'(1);
                end
            end
            DATA: begin
                word_d    = cur_word;
                nib_idx_d = word_end ? '0 : nib_idx_q + NIW'(1);
                if (word_end) begin
                    if (rx_buf_full) begin
                        ovr_err_d = 1'b1;
                    end else begin
                        wr_enb_d  = 1'b1;
                        din_out_d = cur_word;
                    end
                end
                if (block_end) begin
                    state_d   = CRC;
                    crc_cnt_d = '0;
                end else begin
                    nib_rem_d = nib_rem_q - NRW'(1);
                end
            end
            CRC: begin
                crc_cnt_d = crc_cnt_q + 4'd1;
                if (crc_cnt_q == 4'd15) begin
                    state_d = END_BIT;
                end
            end
            END_BIT: begin
                if (DAT_din != 4'b1111) begin
                    end_err_d = 1'b1;
                end
                blk_rem_d = blk_rem_q - CNTW'(1);
                if (blk_rem_q == CNTW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_START;
                    tmo_d   = TMO_LOAD;
                end
            end
            DONE: begin
                fin_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            blk_sz_q  <= '0;
            blk_rem_q <= '0;
            tmo_q     <= '0;
            nib_rem_q <= '0;
            nib_idx_q <= '0;
            word_q    <= '0;
            crc_cnt_q <= '0;
            wr_enb_q  <= 1'b0;
            din_out_q <= '0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            end_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_sz_q  <= blk_sz_d;
            blk_rem_q <= blk_rem_d;
            tmo_q     <= tmo_d;
            nib_rem_q <= nib_rem_d;
            nib_idx_q <= nib_idx_d;
            word_q    <= word_d;
            crc_cnt_q <= crc_cnt_d;
            wr_enb_q  <= wr_enb_d;
            din_out_q <= din_out_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            end_err_q <= end_err_d;
            tmo_err_q <= tmo_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

`ifdef DAT_RX_CRC_EN
    // One serial CRC16 per line. During the CRC cycles the running remainder
    // is shifted out MSB-first and compared with the received bit.
    logic [3:0][15:0] crc_q, crc_d;
    logic             crc_err_q, crc_err_d;

    always_comb begin
        crc_d     = crc_q;
        crc_err_d = crc_err_q;
        case (state_q)
            IDLE: begin
                if (read_flag) begin
                    crc_err_d = 1'b0;
                end
            end
            WAIT_START: begin
                if (DAT_din == 4'b0000) begin
                    crc_d = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < 4; i++) begin
                    crc_d[i] = {crc_q[i][14:0], 1'b0} ^
                               ((crc_q[i][15] ^ DAT_din[i]) ? 16'h1021 : 16'h0000);
                end
            end
            CRC: begin
                for (int i = 0; i < 4; i++) begin
                    if (DAT_din[i] != crc_q[i][15]) begin
                        crc_err_d = 1'b1;
                    end
                    crc_d[i] = {crc_q[i][14:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            crc_q     <= '0;
            crc_err_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign rx_buf_wr_enb  = wr_enb_q;
    assign rx_buf_din_out = din_out_q;
    assign rd_busy        = busy_q;
    assign rd_finished    = fin_q;
    assign end_err        = end_err_q;
    assign timeout_err    = tmo_err_q;
    assign overrun_err    = ovr_err_q;

endmodule
